// File: rtl/eu_exec.sv
// eu_exec: 8-bit execution unit between decode/register file and data memory.
// Ports:
//   clk, reset (async, active low)
//   opAAdr/opBAder     -> opAsendAdr/opBsendAdr : combinational operand address pass-through
//   opcode, operandA, operandB, data_memory_data : operation and operand values
//   dest_reg                                     : consumed externally alongside write_enable
//   storeDataAdr -> storeDataAdrOut              : registered memory write address
//   result, write_enable                         : registered ALU/LOAD result and RF write strobe
//   store_data, data_memory_write_enable         : registered STORE data and memory write strobe
module eu_exec (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opAAdr,
  input  logic [2:0] opBAder,
  input  logic [3:0] opcode,
  input  logic [2:0] dest_reg,
  input  logic [3:0] storeDataAdr,
  output logic [2:0] opAsendAdr,
  output logic [2:0] opBsendAdr,
  output logic [3:0] storeDataAdrOut,
  input  logic [7:0] operandA,
  input  logic [7:0] operandB,
  input  logic [7:0] data_memory_data,
  output logic [7:0] result,
  output logic       write_enable,
  output logic [7:0] store_data,
  output logic       data_memory_write_enable
);

  localparam int unsigned DW = 8;
  localparam int unsigned MW = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_AND   = 4'b0011,
    OP_OR    = 4'b0100,
    OP_XOR   = 4'b0101,
    OP_INC   = 4'b0110,
    OP_DEC   = 4'b0111,
    OP_NOT   = 4'b1000,
    OP_NEG   = 4'b1001,
    OP_SHR   = 4'b1010,
    OP_SHL   = 4'b1011,
    OP_ROR   = 4'b1100,
    OP_ROL   = 4'b1101,
    OP_LOAD  = 4'b1110,
    OP_STORE = 4'b1111
  } op_e;

  op_e           op;
  logic [DW-1:0] result_nxt;
  logic          we_nxt;
  logic [DW-1:0] store_data_nxt;
  logic [MW-1:0] store_adr_nxt;
  logic          dmwe_nxt;

  // dest_reg travels with write_enable to the register file; nothing to do here.
  logic unused_dest;
  assign unused_dest = ^dest_reg;

  // Operand addresses go straight to the register file.
  assign opAsendAdr = opAAdr;
  assign opBsendAdr = opBAder;

  assign op = op_e'(opcode);

  // Next-state for every registered output.
  always_comb begin
    result_nxt     = result;
    we_nxt         = 1'b0;
    store_data_nxt = store_data;
    store_adr_nxt  = storeDataAdrOut;
    dmwe_nxt       = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_ADD:   begin result_nxt = DW'(operandA + operandB);   we_nxt = 1'b1; end
      OP_SUB:   begin result_nxt = DW'(operandA - operandB);   we_nxt = 1'b1; end
      OP_AND:   begin result_nxt = operandA & operandB;        we_nxt = 1'b1; end
      OP_OR:    begin result_nxt = operandA | operandB;        we_nxt = 1'b1; end
      OP_XOR:   begin result_nxt = operandA ^ operandB;        we_nxt = 1'b1; end
      OP_INC:   begin result_nxt = DW'(operandA + 8'd1);       we_nxt = 1'b1; end
      OP_DEC:   begin result_nxt = DW'(operandA - 8'd1);       we_nxt = 1'b1; end
      OP_NOT:   begin result_nxt = ~operandA;                  we_nxt = 1'b1; end
      OP_NEG:   begin result_nxt = DW'(8'd0 - operandA);       we_nxt = 1'b1; end
      OP_SHR:   begin result_nxt = {1'b0, operandA[7:1]};      we_nxt = 1'b1; end
      OP_SHL:   begin result_nxt = {operandA[6:0], 1'b0};      we_nxt = 1'b1; end
      OP_ROR:   begin result_nxt = {operandA[0], operandA[7:1]}; we_nxt = 1'b1; end
      OP_ROL:   begin result_nxt = {operandA[6:0], operandA[7]}; we_nxt = 1'b1; end
      OP_LOAD:  begin result_nxt = data_memory_data;           we_nxt = 1'b1; end
      OP_STORE: begin
        store_data_nxt = operandA;
        store_adr_nxt  = storeDataAdr;
        dmwe_nxt       = 1'b1;
      end
      default:  ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result                   <= '0;
      write_enable             <= 1'b0;
      store_data               <= '0;
      storeDataAdrOut          <= '0;
      data_memory_write_enable <= 1'b0;
    end else begin
      result                   <= result_nxt;
      write_enable             <= we_nxt;
      store_data               <= store_data_nxt;
      storeDataAdrOut          <= store_adr_nxt;
      data_memory_write_enable <= dmwe_nxt;
    end
  end

endmodule

// File: tb/tb_eu_exec.sv
// Self-checking bench for eu_exec: directed test-plan steps followed by random
// operations, all compared against a behavioural model of the opcode table.
module tb_eu_exec;

  logic       clk;
  logic       reset;
  logic [2:0] opAAdr, opBAder, dest_reg;
  logic [3:0] opcode, storeDataAdr;
  logic [2:0] opAsendAdr, opBsendAdr;
  logic [3:0] storeDataAdrOut;
  logic [7:0] operandA, operandB, data_memory_data;
  logic [7:0] result, store_data;
  logic       write_enable, data_memory_write_enable;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [7:0] m_result, m_sd;
  logic [3:0] m_sa;
  logic       m_we, m_dmwe;

  eu_exec dut (
    .clk                      (clk),
    .reset                    (reset),
    .opAAdr                   (opAAdr),
    .opBAder                  (opBAder),
    .opcode                   (opcode),
    .dest_reg                 (dest_reg),
    .storeDataAdr             (storeDataAdr),
    .opAsendAdr               (opAsendAdr),
    .opBsendAdr               (opBsendAdr),
    .storeDataAdrOut          (storeDataAdrOut),
    .operandA                 (operandA),
    .operandB                 (operandB),
    .data_memory_data         (data_memory_data),
    .result                   (result),
    .write_enable             (write_enable),
    .store_data               (store_data),
    .data_memory_write_enable (data_memory_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Opcode table as plain modular arithmetic.
  function automatic logic [7:0] ref_alu(input int op, input int a, input int b, input int mem);
    int r;
    case (op)
      1:  r = a + b;
      2:  r = a - b + 256;
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = a + 1;
      7:  r = a + 255;
      8:  r = 255 - a;
      9:  r = 256 - a;
      10: r = a / 2;
      11: r = a * 2;
      12: r = a / 2 + (a % 2) * 128;
      13: r = a * 2 + a / 128;
      14: r = mem;
      default: r = 0;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".result"}, result, m_result);
    check({tag, ".we"}, {7'd0, write_enable}, {7'd0, m_we});
    check({tag, ".store_data"}, store_data, m_sd);
    check({tag, ".store_adr"}, {4'd0, storeDataAdrOut}, {4'd0, m_sa});
    check({tag, ".dmwe"}, {7'd0, data_memory_write_enable}, {7'd0, m_dmwe});
  endtask

  task automatic model_reset();
    m_result = '0; m_sd = '0; m_sa = '0; m_we = 1'b0; m_dmwe = 1'b0;
  endtask

  // Drive one operation, clock it in, update the model and compare.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] mem, input logic [3:0] adr);
    logic [2:0] aa, ba;
    aa = 3'($urandom_range(0, 7));
    ba = 3'($urandom_range(0, 7));
    opcode = op; operandA = a; operandB = b; data_memory_data = mem;
    storeDataAdr = adr; opAAdr = aa; opBAder = ba; dest_reg = 3'($urandom_range(0, 7));
    #1;
    check({tag, ".opAsend"}, {5'd0, opAsendAdr}, {5'd0, aa});
    check({tag, ".opBsend"}, {5'd0, opBsendAdr}, {5'd0, ba});
    @(posedge clk);
    #1;
    m_we = 1'b0; m_dmwe = 1'b0;
    if (op == 4'd15) begin
      m_sd = a; m_sa = adr; m_dmwe = 1'b1;
    end else if (op != 4'd0) begin
      m_result = ref_alu(int'(op), int'(a), int'(b), int'(mem));
      m_we = 1'b1;
    end
    check_regs(tag);
  endtask

  initial begin
    reset = 1'b0;
    opcode = '0; operandA = '0; operandB = '0; data_memory_data = '0;
    storeDataAdr = '0; opAAdr = '0; opBAder = '0; dest_reg = '0;
    model_reset();

    // Reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset");
    opAAdr = 3'd5; opBAder = 3'd6;
    #1;
    check("rst_passA", {5'd0, opAsendAdr}, 8'd5);
    check("rst_passB", {5'd0, opBsendAdr}, 8'd6);
    reset = 1'b1;

    do_op("add01_02", 4'd1, 8'h01, 8'h02, 8'h00, 4'h0);
    check("add_const", result, 8'h03);
    do_op("load_ab", 4'd14, 8'h00, 8'h00, 8'hAB, 4'h0);
    check("load_const", result, 8'hAB);
    do_op("store", 4'd15, 8'h01, 8'h00, 8'h00, 4'hA);
    check("store_const", store_data, 8'h01);
    check("store_keep_res", result, 8'hAB);
    do_op("nop", 4'd0, 8'h33, 8'h44, 8'h00, 4'h3);
    check("nop_dmwe", {7'd0, data_memory_write_enable}, 8'd0);
    do_op("store_b2b_1", 4'd15, 8'h5A, 8'h00, 8'h00, 4'h7);
    do_op("store_b2b_2", 4'd15, 8'hC3, 8'h00, 8'h00, 4'h2);

    do_op("sub", 4'd2, 8'h05, 8'h03, 8'h00, 4'h0);
    do_op("and", 4'd3, 8'h0F, 8'hF0, 8'h00, 4'h0);
    do_op("or",  4'd4, 8'h0F, 8'hF0, 8'h00, 4'h0);
    do_op("xor", 4'd5, 8'h0F, 8'hF0, 8'h00, 4'h0);
    do_op("add_wrap", 4'd1, 8'hFF, 8'h01, 8'h00, 4'h0);
    check("add_wrap_const", result, 8'h00);
    do_op("sub_wrap", 4'd2, 8'h00, 8'h01, 8'h00, 4'h0);
    check("sub_wrap_const", result, 8'hFF);
    do_op("inc05", 4'd6, 8'h05, 8'h77, 8'h00, 4'h0);
    do_op("dec05", 4'd7, 8'h05, 8'h77, 8'h00, 4'h0);
    do_op("neg05", 4'd9, 8'h05, 8'h77, 8'h00, 4'h0);
    check("neg_const", result, 8'hFB);
    do_op("dec00", 4'd7, 8'h00, 8'h12, 8'h00, 4'h0);
    do_op("incFF", 4'd6, 8'hFF, 8'h12, 8'h00, 4'h0);
    do_op("notAA", 4'd8, 8'hAA, 8'h00, 8'h00, 4'h0);
    do_op("shrAA", 4'd10, 8'hAA, 8'h00, 8'h00, 4'h0);
    do_op("shlAA", 4'd11, 8'hAA, 8'h00, 8'h00, 4'h0);
    check("shl_const", result, 8'h54);
    do_op("rorAA", 4'd12, 8'hAA, 8'h00, 8'h00, 4'h0);
    do_op("rolAA", 4'd13, 8'hAA, 8'h00, 8'h00, 4'h0);
    do_op("ror81", 4'd12, 8'h81, 8'h00, 8'h00, 4'h0);
    check("ror81_const", result, 8'hC0);
    do_op("rol81", 4'd13, 8'h81, 8'h00, 8'h00, 4'h0);
    check("rol81_const", result, 8'h03);

    // Random operations
    for (int i = 0; i < 300; i++) begin
      do_op("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
            8'($urandom), 4'($urandom_range(0, 15)));
    end

    // Build non-zero state then reset asynchronously between edges
    do_op("pre_rst_store", 4'd15, 8'h9C, 8'h00, 8'h00, 4'hD);
    do_op("pre_rst_add", 4'd1, 8'h10, 8'h20, 8'h00, 4'h0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    opAAdr = 3'd1; opBAder = 3'd2;
    #1;
    check("rst_passA2", {5'd0, opAsendAdr}, 8'd1);
    check("rst_passB2", {5'd0, opBsendAdr}, 8'd2);
    @(posedge clk);
    #1;
    check_regs("rst_hold");
    reset = 1'b1;
    do_op("post_rst_xor", 4'd5, 8'h3C, 8'hFF, 8'h00, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eu_exec.md
Name: eu_exec

Overview:
- 8-bit execution unit of the processor datapath, between decode/register-file and data memory.
- Forwards operand register addresses to the register file and receives operand values back in the same cycle.
- Performs a 4-bit-opcode ALU/LOAD/STORE operation and registers the result, register write-enable and memory-store signals on the rising clock edge.

Parameters:
- None. Data width 8, register address width 3, memory address width 4; all fixed.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- opAAdr  input  3  source register address for operand A
- opBAder  input  3  source register address for operand B (port name fixed as spelled)
- opcode  input  4  operation select
- dest_reg  input  3  destination register of the current op; consumed alongside write_enable by the register-file write path, no internal state
- storeDataAdr  input  4  data-memory address for STORE
- opAsendAdr  output  3  operand A address to register file
- opBsendAdr  output  3  operand B address to register file
- storeDataAdrOut  output  4  registered data-memory write address
- operandA  input  8  operand A value from register file
- operandB  input  8  operand B value from register file
- data_memory_data  input  8  data-memory read value for LOAD
- result  output  8  registered ALU/LOAD result
- write_enable  output  1  registered register-file write strobe
- store_data  output  8  registered data to write to memory
- data_memory_write_enable  output  1  registered memory write strobe

Behaviour:
- opAsendAdr = opAAdr and opBsendAdr = opBAder, purely combinational; unaffected by reset.
- All other outputs are flops. reset low forces them to 0 immediately (asynchronously): result=00, write_enable=0, store_data=00, storeDataAdrOut=0, data_memory_write_enable=0.
- Flops hold 0 while reset is low; the first capture is on the first rising edge after reset goes high.
- Latency: the operation presented before a rising edge is visible on the outputs after that edge (1 cycle). There is no handshake; one operation is accepted per cycle.
- Opcode map (A=operandA, B=operandB, all arithmetic mod 256, carries and borrows discarded):
  - 0000 NOP: write_enable=0; result holds.
  - 0001 ADD: A+B
  - 0010 SUB: A-B
  - 0011 AND: A&B
  - 0100 OR: A|B
  - 0101 XOR: A^B
  - 0110 INC: A+1
  - 0111 DEC: A-1
  - 1000 NOT: ~A
  - 1001 NEG: two's complement, 0-A
  - 1010 SHR: logical right by 1, MSB filled with 0
  - 1011 SHL: left by 1, LSB filled with 0
  - 1100 ROR: {A[0],A[7:1]}
  - 1101 ROL: {A[6:0],A[7]}
  - 1110 LOAD: result=data_memory_data
  - 1111 STORE: store_data=A, storeDataAdrOut=storeDataAdr, data_memory_write_enable=1; write_enable=0; result holds.
- For opcodes 0001-1110, write_enable=1 for the cycle after the edge.
- data_memory_write_enable is 1 only for the cycle following a STORE edge and returns to 0 on the next non-STORE edge.
- store_data and storeDataAdrOut hold their last STORE values otherwise.
- operandB is ignored by the unary ops (INC through ROL).
- Back-to-back identical ops each re-assert their strobes; no edge detection.
- Reset asserted mid-operation clears all flops immediately. The pending operation is lost.
- No flags and no status outputs.

Test Plan:
- Reset low with clock running -> all registered outputs 0. Release reset, ADD A=01 B=02, dest_reg=2 -> after 1 edge result=03, write_enable=1.
- LOAD with data_memory_data=AB -> result=AB, write_enable=1. Then STORE A=01, storeDataAdr=A -> store_data=01, storeDataAdrOut=A, data_memory_write_enable=1, write_enable=0, result stays AB. Next NOP -> data_memory_write_enable=0.
- Binary ops, one per cycle:
  - SUB 05-03 -> 02
  - AND 0F,F0 -> 00
  - OR 0F,F0 -> FF
  - XOR 0F,F0 -> FF
  - Wrap cases: ADD FF+01 -> 00; SUB 00-01 -> FF.
- Unary ops on A=05:
  - INC -> 06
  - DEC -> 04
  - NEG -> FB
  - Wrap cases: DEC 00 -> FF; INC FF -> 00.
- Unary ops on A=AA:
  - NOT -> 55
  - SHR -> 55
  - SHL -> 54
  - ROR -> 55
  - ROL -> 55
  - With A=81: ROR -> C0, ROL -> 03.
- Change opAAdr/opBAder between edges -> opAsendAdr/opBsendAdr follow with zero delay, including while reset is low. Assert reset mid-stream -> outputs clear without waiting for a clock edge.
